// File: rtl/hw3_pkg.sv
// Shared definitions for the HW3 sync-pattern link (transmitter and detector).
package hw3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } tx_state_e;

  localparam logic [6:0] SYNC_PAT_DEF = 7'b1101101;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/hw3_piso.sv
// Parallel-in serial-out shift register, MSB first; load has priority over shift.
module hw3_piso #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] par_i,
  output logic         msb_o
);

  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = par_i;
    end else if (shift_i) begin
      sr_d = {sr_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb_o = sr_q[W-1];

endmodule

// File: rtl/hw3_sync_tx.sv
// Serial sync framer: sync pattern, payload (both MSB first), then idle zeros.
// Accepts one payload per frame via valid/ready; ready only while idle.
module hw3_sync_tx
  import hw3_pkg::*;
#(
  parameter int                SYNC_W     = 7,
  parameter logic [SYNC_W-1:0] SYNC_PAT   = SYNC_PAT_DEF,
  parameter int                DATA_W     = 8,
  parameter int                GAP_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_data,
  output logic              o_sof,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(max3(SYNC_W, DATA_W, GAP_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] SYNC_LD = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LD = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             data_q, data_d;
  logic             sof_q, sof_d;
  logic [CNT_W-1:0] cnt_m1;
  logic             sync_bit;
  logic             piso_load;
  logic             piso_shift;
  logic             piso_msb;

  hw3_piso #(
    .W (DATA_W)
  ) u_piso (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .load_i  (piso_load),
    .shift_i (piso_shift),
    .par_i   (i_data),
    .msb_o   (piso_msb)
  );

  assign cnt_m1 = cnt_q - CNT_W'(1);
  // Next sync bit to put on the wire is indexed by the decremented count.
  assign sync_bit = 1'(SYNC_PAT >> cnt_m1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = 1'b0;
    sof_d      = 1'b0;
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          state_d   = ST_SYNC;
          cnt_d     = SYNC_LD;
          data_d    = SYNC_PAT[SYNC_W-1];
          sof_d     = 1'b1;
          piso_load = 1'b1;
        end
      end
      ST_SYNC: begin
        if (cnt_q == '0) begin
          state_d    = ST_DATA;
          cnt_d      = DATA_LD;
          data_d     = piso_msb;
          piso_shift = 1'b1;
        end else begin
          cnt_d  = cnt_m1;
          data_d = sync_bit;
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d      = cnt_m1;
          data_d     = piso_msb;
          piso_shift = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_m1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= 1'b0;
      sof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      sof_q   <= sof_d;
    end
  end

  assign o_ready = (state_q == ST_IDLE);
  assign o_busy  = (state_q != ST_IDLE);
  assign o_data  = data_q;
  assign o_sof   = sof_q;

endmodule

// File: tb/tb_hw3_sync_tx.sv
// Bench for hw3_sync_tx: default instance plus a DATA_W=16 / GAP_CYCLES=4 instance,
// both checked every cycle against a frame-position reference model.
module tb_hw3_sync_tx;

  localparam int LEN_A = 7 + 8 + 1;
  localparam int LEN_B = 7 + 16 + 4;

  logic        clk;
  logic        rst_n;
  logic        valid_a, valid_b;
  logic [7:0]  data_a;
  logic [15:0] data_b;
  logic        o_ready_a, o_data_a, o_sof_a, o_busy_a;
  logic        o_ready_b, o_data_b, o_sof_b, o_busy_b;

  int total = 0;
  int bad   = 0;

  hw3_sync_tx u_a (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (valid_a),
    .i_data  (data_a),
    .o_ready (o_ready_a),
    .o_data  (o_data_a),
    .o_sof   (o_sof_a),
    .o_busy  (o_busy_a)
  );

  hw3_sync_tx #(
    .DATA_W     (16),
    .GAP_CYCLES (4)
  ) u_b (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (valid_b),
    .i_data  (data_b),
    .o_ready (o_ready_b),
    .o_data  (o_data_b),
    .o_sof   (o_sof_b),
    .o_busy  (o_busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected bit n of a frame: 7 sync bits, dw payload bits, then zeros.
  function automatic logic exp_bit(input logic [15:0] pay, input int dw, input int n);
    logic [6:0] sp;
    sp = 7'b1101101;
    if (n < 7) return sp[6-n];
    if (n < 7 + dw) return pay[dw-1-(n-7)];
    return 1'b0;
  endfunction

  // Reference model: position inside the current frame, -1 when idle.
  int          pos_a = -1, pos_b = -1;
  logic [15:0] pay_a = '0, pay_b = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_a = -1;
      pos_b = -1;
    end else begin
      if (pos_a < 0) begin
        if (valid_a) begin
          pos_a = 0;
          pay_a = {8'h00, data_a};
        end
      end else begin
        pos_a++;
        if (pos_a == LEN_A) pos_a = -1;
      end
      if (pos_b < 0) begin
        if (valid_b) begin
          pos_b = 0;
          pay_b = data_b;
        end
      end else begin
        pos_b++;
        if (pos_b == LEN_B) pos_b = -1;
      end
    end
  end

  // Per-cycle comparison plus statistics; a 7-bit window stands in for the detector.
  int         cyc = 0;
  logic       prev_sof_a = 1'b0, prev_sof_b = 1'b0;
  logic [6:0] win_a = '0;
  int sof_cnt_a = 0, sof_gap_a = 0, last_sof_a = 0, rdy_low_a = 0;
  int hits_a = 0, hits_sync_a = 0;
  int sof_gap_b = 0, last_sof_b = 0, rdy_low_b = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      win_a      = '0;
      prev_sof_a = 1'b0;
      prev_sof_b = 1'b0;
    end else begin
      check("a_data",  o_data_a,  (pos_a < 0) ? 1'b0 : exp_bit(pay_a, 8, pos_a));
      check("a_sof",   o_sof_a,   pos_a == 0);
      check("a_busy",  o_busy_a,  pos_a >= 0);
      check("a_ready", o_ready_a, pos_a < 0);
      check("a_sof_twice", o_sof_a & prev_sof_a, 0);
      check("b_data",  o_data_b,  (pos_b < 0) ? 1'b0 : exp_bit(pay_b, 16, pos_b));
      check("b_sof",   o_sof_b,   pos_b == 0);
      check("b_busy",  o_busy_b,  pos_b >= 0);
      check("b_ready", o_ready_b, pos_b < 0);
      check("b_sof_twice", o_sof_b & prev_sof_b, 0);
      prev_sof_a = o_sof_a;
      prev_sof_b = o_sof_b;
      if (o_sof_a) begin
        sof_cnt_a++;
        sof_gap_a  = cyc - last_sof_a;
        last_sof_a = cyc;
      end
      if (o_sof_b) begin
        sof_gap_b  = cyc - last_sof_b;
        last_sof_b = cyc;
      end
      if (!o_ready_a) rdy_low_a++;
      if (!o_ready_b) rdy_low_b++;
      win_a = {win_a[5:0], o_data_a};
      if (win_a == 7'b1101101) begin
        hits_a++;
        if (pos_a == 6) hits_sync_a++;
      end
    end
  end

  task automatic clr_stats();
    #1;
    sof_cnt_a   = 0;
    rdy_low_a   = 0;
    rdy_low_b   = 0;
    hits_a      = 0;
    hits_sync_a = 0;
  endtask

  // Offer a payload and hold it until accepted; afterwards the data bus wanders.
  task automatic send(input bit to_b, input logic [15:0] d);
    int w;
    w = 0;
    if (to_b) begin
      valid_b = 1'b1;
      data_b  = d;
    end else begin
      valid_a = 1'b1;
      data_a  = d[7:0];
    end
    while (!(to_b ? o_ready_b : o_ready_a) && w < 200) begin
      @(negedge clk);
      w++;
    end
    check(to_b ? "b_accept" : "a_accept", w < 200, 1);
    @(negedge clk);
    if (to_b) begin
      valid_b = 1'b0;
      data_b  = 16'($urandom);
    end else begin
      valid_a = 1'b0;
      data_a  = 8'($urandom);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data_a = 8'($urandom);
      data_b = 16'($urandom);
    end
  endtask

  initial begin
    int w;
    rst_n   = 1'b1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    data_a  = '0;
    data_b  = '0;

    #3 rst_n = 1'b0;
    #1;
    check("rst_data", o_data_a, 0);
    check("rst_sof",  o_sof_a,  0);
    check("rst_busy", o_busy_a, 0);
    check("rst_busy_b", o_busy_b, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready_a", o_ready_a, 1);
    check("rel_ready_b", o_ready_b, 1);

    clr_stats();
    send(1'b0, 16'h00A5);
    idle(20);
    check("a5_ready_low", rdy_low_a, 16);
    check("a5_sof_cnt",   sof_cnt_a, 1);

    send(1'b0, 16'h0000);
    send(1'b0, 16'h00FF);
    idle(2);
    check("b2b_sof_gap", sof_gap_a, 17);
    idle(20);

    clr_stats();
    for (int i = 0; i < 4; i++) send(1'b0, 16'h0000);
    idle(20);
    check("loop00_hits",      hits_a,      4);
    check("loop00_hits_sync", hits_sync_a, 4);

    clr_stats();
    send(1'b0, 16'h00DB);
    idle(20);
    check("loopdb_hits",      hits_a,      2);
    check("loopdb_hits_sync", hits_sync_a, 1);

    send(1'b0, 16'h005A);
    w = 0;
    while (pos_a != 10 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("midrst_reach", w < 50, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_data", o_data_a, 0);
    check("midrst_sof",  o_sof_a,  0);
    check("midrst_busy", o_busy_a, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready", o_ready_a, 1);
    clr_stats();
    send(1'b0, 16'h003C);
    idle(20);
    check("post_rst_sof_cnt",   sof_cnt_a,   1);
    check("post_rst_hits_sync", hits_sync_a, 1);

    clr_stats();
    send(1'b1, 16'h1234);
    send(1'b1, 16'hBEEF);
    idle(2);
    check("sweep_sof_gap", sof_gap_b, 28);
    idle(40);
    check("sweep_ready_low", rdy_low_b, 54);

    for (int i = 0; i < 12; i++) begin
      send(1'b0, 16'($urandom));
      idle($urandom_range(0, 3));
    end
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 16'($urandom));
      idle($urandom_range(0, 3));
    end
    idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hw3_sync_tx.md
# hw3_sync_tx

Serial sync-framer: the transmit end of the 7-bit sync-pattern link whose receiver is the HW3 pattern detector. Accepts a parallel payload word over a valid/ready handshake and emits a one-bit-per-cycle stream: the sync pattern 1101101 (MSB first), the payload (MSB first), then a mandatory idle gap of zeros. Drives the detector's serial `i_data` input directly in the loopback bench.

## Interface
- `SYNC_W`, 7: sync pattern width in bits.
- `SYNC_PAT`, 7'b1101101: sync pattern; bit `SYNC_W-1` is sent first.
- `DATA_W`, 8: payload width in bits.
- `GAP_CYCLES`, 1: idle-zero cycles after each payload; legal range is 1 to 15.

Ports (one clock; reset is asynchronous and active-low):
- `i_clk`  in  1  system clock; all state changes on the rising edge.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_valid`  in  1  payload offered.
- `i_data`  in  DATA_W  payload word; sampled only on handshake.
- `o_ready`  out  1  transmitter idle and able to accept.
- `o_data`  out  1  serial output bit, registered.
- `o_sof`  out  1  one-cycle pulse coinciding with the first sync bit on `o_data`.
- `o_busy`  out  1  high while sync, payload or gap is in progress.

## Operation
- FSM states:
  - IDLE → SYNC on handshake (`i_valid && o_ready` at a rising edge).
  - SYNC → DATA after `SYNC_W` bits.
  - DATA → GAP after `DATA_W` bits.
  - GAP → IDLE after `GAP_CYCLES` cycles.
- Handshake:
  - `o_ready` = (state == IDLE), decoded from registered state only.
  - The payload is captured into a shift register on the handshake edge.
  - `i_valid` is ignored outside IDLE. The source holds `i_valid`/`i_data` until accepted.
- Outputs by state:
  - `o_data` = 0 in IDLE and GAP.
  - `o_data` carries `SYNC_PAT[SYNC_W-1-n]` on SYNC bit n.
  - `o_data` carries `payload[DATA_W-1-n]` on DATA bit n.
- Counter:
  - One shared down-counter, width `$clog2(max(SYNC_W, DATA_W, GAP_CYCLES))+1`.
  - Reloaded on every state entry; the state advances when the count reaches 0.
- Payload aliasing:
  - The payload is not scrambled or stuffed.
  - A payload containing the sync pattern, or overlapping it, produces extra detector hits. This is link-level behaviour, not a transmitter error.
- Reset (async, any time):
  - State returns to IDLE.
  - `o_data`=0, `o_sof`=0, `o_busy`=0, `o_ready`=1 (after release), counter and shift register cleared.
  - A frame in flight is abandoned, not resumed.

## Timing
- Handshake at edge k:
  - `o_sof`=1 and the first sync bit are on `o_data` during cycle k+1.
  - Sync occupies cycles k+1..k+SYNC_W.
  - Payload occupies k+SYNC_W+1..k+SYNC_W+DATA_W.
  - Gap occupies the next `GAP_CYCLES` cycles.
  - `o_ready` rises in cycle k+SYNC_W+DATA_W+GAP_CYCLES+1.
- Frame period with `i_valid` held high = 1 + SYNC_W + DATA_W + GAP_CYCLES cycles. With defaults, the sync start repeats every 17 cycles.
- `o_busy` = !`o_ready` except during reset.
- `o_sof` is never high for two consecutive cycles.

## Structure
- Shared package `hw3_pkg`:
  - FSM state encoding (IDLE, SYNC, DATA, GAP, 2 bits).
  - Default `SYNC_PAT` constant 7'b1101101, shared with the detector.
- One sub-module, `hw3_piso`:
  - Parallel-load, MSB-first, parameterised-width shift register with load and shift enables.
  - Instantiated once for the payload.
  - The sync bits are indexed from `SYNC_PAT` by the counter, not shifted.
- Top holds the FSM, counter and output registers.

## Test plan
- **Reset values:** assert `i_rst_n`=0 mid-cycle with no clock edge → `o_data`=0, `o_sof`=0, `o_busy`=0 immediately; `o_ready`=1 after release.
- **Single frame:** `i_data`=8'hA5, `i_valid` one cycle → `o_data` sequence 1101101_10100101_0. `o_sof` high exactly one cycle, aligned with the first bit. `o_ready` low for 16 cycles.
- **Back-to-back:** `i_valid` held high with 8'h00 then 8'hFF → the second `o_sof` comes exactly 17 cycles after the first. `i_data` changes while busy do not alter the serial payload.
- **Loopback with detector:** 4 frames of 8'h00 → detector `o_find` pulses exactly 4 times, each immediately after the 7th sync bit. Payload 8'hDB (11011011) → the detector reports an additional hit inside the payload, as documented.
- **Reset mid-frame:** reset asserted during payload bit 3 → outputs return to reset values at once. After release, a new 8'h3C frame is sent cleanly with a full sync.
- **Parameter sweep:** `GAP_CYCLES`=4, `DATA_W`=16 → period = 1+7+16+4 = 28 cycles, with 4 zero cycles before `o_ready`.
